// File: rtl/prbs31_pkg.sv
// Shared types and constants for the PRBS31 sequencing block.
// Holds the controller state encoding and the generator width and default seed.
package prbs31_pkg;

  localparam int PRBS_W = 31;
  localparam logic [PRBS_W-1:0] PRBS_SEED_DEFAULT = 31'h7FFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SYNC,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. Clear has priority over increment.
// Updates one cycle after inc/clr; it never applies backpressure and holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/prbs31_seq_ctrl.sv
// Sequencer for a PRBS31 generator/checker pair: seed load, lock search, counted burst, error tally.
// start gives gen_load next cycle and gen_en the cycle after; no backpressure, abort idles in one cycle.
module prbs31_seq_ctrl
  import prbs31_pkg::*;
#(
  parameter int LEN_W     = 16,
  parameter int ERR_W     = 8,
  parameter int LOCK_BITS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [PRBS_W-1:0] seed,
  input  logic              inject_err,
  output logic              gen_load,
  output logic [PRBS_W-1:0] gen_seed,
  output logic              gen_en,
  output logic              gen_flip,
  output logic              chk_en,
  input  logic              chk_err,
  output logic              busy,
  output logic              done,
  output logic              locked,
  output logic [ERR_W-1:0]  err_count,
  output logic [LEN_W-1:0]  bit_count
);

  localparam int SYNC_LIMIT = 4 * LOCK_BITS;
  localparam int CLEAN_W    = $clog2(LOCK_BITS + 1);
  localparam int SYNC_W     = $clog2(SYNC_LIMIT + 1);

  state_t             state;
  logic               run_en;
  logic               flip_pend;
  logic [LEN_W-1:0]   len_q;
  logic [CLEAN_W-1:0] clean_cnt;
  logic [SYNC_W-1:0]  sync_cnt;
  logic               abort_now;
  logic               err_inc;
  logic               err_clr;

  assign abort_now = abort && (state != ST_IDLE);

  // Enables drop in the abort cycle itself so no bit is stepped or checked there.
  assign gen_en   = run_en && !abort_now;
  assign chk_en   = run_en && !abort_now;
  assign gen_flip = flip_pend && (state == ST_RUN) && !abort_now;

  assign err_inc = (state == ST_RUN) && chk_err && !abort_now;
  assign err_clr = (state == ST_IDLE) && start;

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (err_clr),
    .inc   (err_inc),
    .count (err_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      gen_load  <= 1'b0;
      gen_seed  <= '0;
      run_en    <= 1'b0;
      locked    <= 1'b0;
      bit_count <= '0;
      len_q     <= '0;
      clean_cnt <= '0;
      sync_cnt  <= '0;
      flip_pend <= 1'b0;
    end else begin
      gen_load <= 1'b0;
      done     <= 1'b0;

      // A request landing in the cycle a flip is issued merges into that flip.
      if (state == ST_IDLE || gen_flip) begin
        flip_pend <= 1'b0;
      end else if (inject_err) begin
        flip_pend <= 1'b1;
      end

      if (abort_now) begin
        state  <= ST_IDLE;
        busy   <= 1'b0;
        run_en <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              len_q     <= burst_len;
              gen_seed  <= (seed == '0) ? PRBS_SEED_DEFAULT : seed;
              bit_count <= '0;
              locked    <= 1'b0;
              busy      <= 1'b1;
              gen_load  <= 1'b1;
              state     <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            clean_cnt <= '0;
            sync_cnt  <= '0;
            run_en    <= 1'b1;
            state     <= ST_SYNC;
          end
          ST_SYNC: begin
            clean_cnt <= chk_err ? '0 : clean_cnt + CLEAN_W'(1);
            sync_cnt  <= sync_cnt + SYNC_W'(1);
            if (!chk_err && (clean_cnt == CLEAN_W'(LOCK_BITS - 1))) begin
              locked <= 1'b1;
              state  <= ST_RUN;
            end else if (sync_cnt == SYNC_W'(SYNC_LIMIT - 1)) begin
              run_en <= 1'b0;
              done   <= 1'b1;
              state  <= ST_DONE;
            end
          end
          ST_RUN: begin
            bit_count <= bit_count + LEN_W'(1);
            if ((len_q != '0) && ((bit_count + LEN_W'(1)) == len_q)) begin
              run_en <= 1'b0;
              done   <= 1'b1;
              state  <= ST_DONE;
            end
          end
          ST_DONE: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: begin
            busy   <= 1'b0;
            run_en <= 1'b0;
            state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs31_seq_ctrl.sv
// Bench for prbs31_seq_ctrl: scoreboarded burst results plus directed timing and control checks.
module tb_prbs31_seq_ctrl;

  typedef struct {
    logic        lk;
    logic [15:0] bits;
    logic [7:0]  errs;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] burst_len;
  logic [30:0] seed;
  logic        inject_err;
  logic        gen_load;
  logic [30:0] gen_seed;
  logic        gen_en;
  logic        gen_flip;
  logic        chk_en;
  logic        chk_err;
  logic        busy;
  logic        done;
  logic        locked;
  logic [7:0]  err_count;
  logic [15:0] bit_count;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;
  int   en_cyc;
  int   flip_cyc;
  int   sync_cyc;
  int   done_cnt;
  bit   saw_done;
  int   mode;
  int   bitn;

  prbs31_seq_ctrl #(.LEN_W(16), .ERR_W(8), .LOCK_BITS(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .burst_len  (burst_len),
    .seed       (seed),
    .inject_err (inject_err),
    .gen_load   (gen_load),
    .gen_seed   (gen_seed),
    .gen_en     (gen_en),
    .gen_flip   (gen_flip),
    .chk_en     (chk_en),
    .chk_err    (chk_err),
    .busy       (busy),
    .done       (done),
    .locked     (locked),
    .err_count  (err_count),
    .bit_count  (bit_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Checker model: 0 ideal, 1 sees every generator flip, 2 errors on all locked bits, 3 every 10th bit.
  always @(posedge clk) begin
    if (gen_load) bitn <= 0;
    else if (chk_en) bitn <= bitn + 1;
  end

  assign chk_err = (mode == 1) ? gen_flip :
                   (mode == 2) ? (chk_en && locked) :
                   (mode == 3) ? (chk_en && (bitn % 10 == 9)) : 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (gen_en) en_cyc++;
    if (gen_flip) flip_cyc++;
    if (gen_en && !locked) sync_cyc++;
    if (done) begin
      done_cnt++;
      saw_done = 1'b1;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("done_locked", 64'(locked), 64'(e.lk));
        check("done_bits", 64'(bit_count), 64'(e.bits));
        check("done_errs", 64'(err_count), 64'(e.errs));
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 64'({busy, done, gen_load, gen_en, chk_en, gen_flip, locked}), 64'(0));
    check({tag, "_seed"}, 64'(gen_seed), 64'(0));
    check({tag, "_cnt"}, 64'({err_count, bit_count}), 64'(0));
  endtask

  task automatic start_run(input int len, input logic [30:0] sd, input bit push, input exp_t e,
                           input logic [30:0] exp_seed, input bit with_abort);
    start      = 1'b1;
    abort      = with_abort;
    burst_len  = len[15:0];
    seed       = sd;
    if (push) exp_q.push_back(e);
    en_cyc   = 0;
    flip_cyc = 0;
    sync_cyc = 0;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("load_pulse", 64'(gen_load), 64'(1));
    check("load_seed", 64'(gen_seed), 64'(exp_seed));
    check("load_no_en", 64'(gen_en), 64'(0));
    tick();
    check("first_en", 64'(gen_en), 64'(1));
    check("load_once", 64'(gen_load), 64'(0));
  endtask

  task automatic wait_done(input int budget);
    saw_done = 1'b0;
    for (int i = 0; i < budget && !saw_done; i++) tick();
    check("done_seen", 64'(saw_done), 64'(1));
    tick();
    check("done_one_cycle", 64'(done), 64'(0));
    check("idle_after_done", 64'(busy), 64'(0));
  endtask

  task automatic wait_bits(input int n, input int budget);
    for (int i = 0; i < budget && bit_count != n[15:0]; i++) tick();
    check("wait_bits", 64'(bit_count), 64'(n));
  endtask

  task automatic wait_lock(input int budget);
    for (int i = 0; i < budget && !locked; i++) tick();
    check("wait_lock", 64'(locked), 64'(1));
  endtask

  initial begin
    int   d0;
    exp_t e;
    vectors     = 0;
    miscompares = 0;
    done_cnt    = 0;
    saw_done    = 1'b0;
    en_cyc      = 0;
    flip_cyc    = 0;
    sync_cyc    = 0;
    mode        = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    burst_len   = '0;
    seed        = '0;
    inject_err  = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // Ideal checker, 100-bit burst
    e = '{lk: 1'b1, bits: 16'd100, errs: 8'd0};
    start_run(100, 31'h1234567, 1'b1, e, 31'h1234567, 1'b0);
    wait_done(300);
    check("sync_cycles", 64'(sync_cyc), 64'(32));
    check("total_en_cycles", 64'(en_cyc), 64'(132));
    check("hold_bits", 64'(bit_count), 64'(100));
    check("hold_locked", 64'(locked), 64'(1));

    // All-zero seed substitution
    e = '{lk: 1'b1, bits: 16'd5, errs: 8'd0};
    start_run(5, 31'h0, 1'b1, e, 31'h7FFFFFFF, 1'b0);
    wait_done(100);
    check("short_en_cycles", 64'(en_cyc), 64'(37));

    // Injected flip: IDLE request discarded, back-to-back RUN requests merge
    mode = 1;
    inject_err = 1'b1;
    tick();
    inject_err = 1'b0;
    e = '{lk: 1'b1, bits: 16'd100, errs: 8'd1};
    start_run(100, 31'h0ABCDEF, 1'b1, e, 31'h0ABCDEF, 1'b0);
    wait_lock(100);
    repeat (5) tick();
    inject_err = 1'b1;
    tick();
    tick();
    inject_err = 1'b0;
    wait_done(300);
    check("flip_cycles", 64'(flip_cyc), 64'(1));

    // Error counter saturation
    mode = 2;
    e = '{lk: 1'b1, bits: 16'd300, errs: 8'd255};
    start_run(300, 31'h00F00F0, 1'b1, e, 31'h00F00F0, 1'b0);
    wait_done(500);

    // No lock: SYNC timeout
    mode = 3;
    e = '{lk: 1'b0, bits: 16'd0, errs: 8'd0};
    start_run(100, 31'h1111111, 1'b1, e, 31'h1111111, 1'b0);
    wait_done(300);
    check("timeout_sync_cycles", 64'(sync_cyc), 64'(128));

    // Abort mid-RUN at bit 50
    mode = 0;
    start_run(200, 31'h5A5A5A5, 1'b0, e, 31'h5A5A5A5, 1'b0);
    wait_bits(50, 200);
    d0 = done_cnt;
    abort = 1'b1;
    #1;
    check("abort_gen_en", 64'(gen_en), 64'(0));
    check("abort_chk_en", 64'(chk_en), 64'(0));
    tick();
    abort = 1'b0;
    check("abort_idle", 64'(busy), 64'(0));
    check("abort_bits", 64'(bit_count), 64'(50));
    check("abort_en_next", 64'(gen_en), 64'(0));
    repeat (4) tick();
    check("abort_no_done", 64'(done_cnt), 64'(d0));

    // Start wins over abort in IDLE; abort wins over end of burst
    start_run(10, 31'h2222222, 1'b0, e, 31'h2222222, 1'b1);
    wait_bits(9, 100);
    d0 = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("eob_abort_idle", 64'(busy), 64'(0));
    check("eob_abort_bits", 64'(bit_count), 64'(9));
    repeat (3) tick();
    check("eob_abort_no_done", 64'(done_cnt), 64'(d0));

    // Reset mid-RUN, then start accepted on the first edge with reset released
    start_run(200, 31'h3333333, 1'b0, e, 31'h3333333, 1'b0);
    wait_bits(20, 100);
    rst_n = 1'b0;
    tick();
    check_zero("midrun_reset");
    rst_n = 1'b1;
    e = '{lk: 1'b1, bits: 16'd10, errs: 8'd0};
    start_run(10, 31'h0000003, 1'b1, e, 31'h0000003, 1'b0);
    wait_done(100);

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
